// File: rtl/mbf_rom_sched.sv
// ROM fetch scheduler: sequences 1024x4 ROM reads and broadcasts each nibble to
// the LPF and HPF through a 2-entry skid buffer, with a credit-based issue rule.
module mbf_rom_sched #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rom_cen,
  output logic [ADDR_W-1:0] rom_a,
  input  logic [DATA_W-1:0] rom_q,
  input  logic              lpf_ready,
  input  logic              hpf_ready,
  output logic              x_valid,
  output logic [DATA_W-1:0] x_half,
  output logic              x_first,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_pending, r_pend_first;
  logic [1:0]          r_count;
  logic [DATA_W-1:0]   r_d0, r_d1;
  logic                r_f0, r_f1;
  logic                r_done;
  logic                w_pop, w_issue, w_last, w_done_nxt;
  logic [2:0]          w_occ;

  always_comb begin
    w_pop       = (r_count != 2'd0) & lpf_ready & hpf_ready;
    // Credit counts the in-flight read so a full buffer can never be overrun.
    w_occ       = {1'b0, r_count} + {2'b00, r_pending} - {2'b00, w_pop};
    w_issue     = (r_state == S_FETCH) && (w_occ < 3'd2);
    w_last      = (r_addr == ADDR_W'(DEPTH - 1));
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: if (w_issue && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (!r_pending && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_pending    <= 1'b0;
      r_pend_first <= 1'b0;
      r_count      <= 2'd0;
      r_d0         <= '0;
      r_d1         <= '0;
      r_f0         <= 1'b0;
      r_f1         <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_done_nxt;
      r_pending <= w_issue;
      if (w_issue) r_pend_first <= ~r_addr[0];
      if ((r_state == S_IDLE) && start) r_addr <= '0;
      else if (w_issue && !w_last)      r_addr <= r_addr + ADDR_W'(1);
      // Entry 0 is always the head; a pop shifts entry 1 forward.
      case ({r_pending, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_d0 <= rom_q;
            r_f0 <= r_pend_first;
          end else begin
            r_d1 <= rom_q;
            r_f1 <= r_pend_first;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_d0    <= r_d1;
          r_f0    <= r_f1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_d0 <= rom_q;
            r_f0 <= r_pend_first;
          end else begin
            r_d0 <= r_d1;
            r_f0 <= r_f1;
            r_d1 <= rom_q;
            r_f1 <= r_pend_first;
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_cen = ~w_issue;
  assign rom_a   = r_addr;
  assign x_valid = (r_count != 2'd0);
  assign x_half  = r_d0;
  assign x_first = r_f0;
  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;

endmodule

// File: tb/tb_mbf_rom_sched.sv
// Directed bench for mbf_rom_sched with a behavioural 1024x4 synchronous ROM.
module tb_mbf_rom_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rom_cen;
  logic [9:0] rom_a;
  logic [3:0] rom_q = 4'h0;
  logic       lpf_ready = 1'b0;
  logic       hpf_ready = 1'b0;
  logic       x_valid;
  logic [3:0] x_half;
  logic       x_first;
  logic       busy;
  logic       done;

  logic [3:0] mem [0:1023];
  int checks = 0;
  int failures = 0;

  mbf_rom_sched #(.DEPTH(1024), .ADDR_W(10), .DATA_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_cen(rom_cen), .rom_a(rom_a),
    .rom_q(rom_q), .lpf_ready(lpf_ready), .hpf_ready(hpf_ready), .x_valid(x_valid),
    .x_half(x_half), .x_first(x_first), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (!rom_cen) rom_q <= mem[rom_a];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; lpf_ready = 1'b0; hpf_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({rom_cen, rom_a, x_valid, x_half, x_first, busy, done} !== {1'b1, 10'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got cen=%b a=%0d v=%b h=%h f=%b busy=%b done=%b exp 1 0 0 0 0 0 0",
               rom_cen, rom_a, x_valid, x_half, x_first, busy, done);
    end
    tick();
  endtask

  task automatic test_full_run();
    logic ev, ef;
    int k;
    do_reset();
    lpf_ready = 1'b1; hpf_ready = 1'b1;
    for (int cyc = 0; cyc <= 1030; cyc++) begin
      start = (cyc == 0);
      #1;
      ev = (cyc >= 3) && (cyc <= 1026);
      checks++;
      if (x_valid !== ev) begin
        failures++;
        $display("FAIL full_valid cyc%0d got %b exp %b", cyc, x_valid, ev);
      end
      if (ev) begin
        k = cyc - 3;
        ef = ~k[0];
        checks++;
        if (x_half !== mem[k] || x_first !== ef) begin
          failures++;
          $display("FAIL full_data cyc%0d got %h/%b exp %h/%b", cyc, x_half, x_first, mem[k], ef);
        end
      end
      checks++;
      if (done !== (cyc == 1027) || busy !== (cyc >= 1 && cyc < 1027) || rom_cen !== !(cyc >= 1 && cyc <= 1024)) begin
        failures++;
        $display("FAIL full_ctl cyc%0d got done=%b busy=%b cen=%b", cyc, done, busy, rom_cen);
      end
      tick();
    end
    start = 1'b0;
  endtask

  // mode 0: random readies, mode 1: 20-cycle hpf stall at pop 100, mode 2: stray start at cycle 100
  task automatic run_collect(input int mode, input string name);
    int idx = 0, dones = 0, cyc = 0, stall = 0, post = 0;
    logic [3:0] hold_d;
    logic hold_f, ef;
    bit stalling;
    do_reset();
    while (cyc < 20000 && post < 6) begin
      start = (cyc == 0) || (mode == 2 && cyc == 100);
      stalling = (mode == 1) && (idx == 100) && (stall < 20);
      if (mode == 0) begin
        lpf_ready = ($urandom_range(0, 3) != 0);
        hpf_ready = ($urandom_range(0, 3) != 0);
      end else begin
        lpf_ready = 1'b1;
        hpf_ready = !stalling;
      end
      #1;
      if (stalling) begin
        if (stall == 0) begin hold_d = x_half; hold_f = x_first; end
        stall++;
        checks++;
        if (rom_cen !== 1'b1 || x_valid !== 1'b1 || x_half !== hold_d || x_first !== hold_f) begin
          failures++;
          $display("FAIL %s stall%0d got cen=%b v=%b h=%h f=%b exp 1 1 %h %b",
                   name, stall, rom_cen, x_valid, x_half, x_first, hold_d, hold_f);
        end
      end
      if (x_valid && lpf_ready && hpf_ready) begin
        checks++;
        if (idx >= 1024) begin
          failures++;
          $display("FAIL %s extra_pop got %0d exp 1024", name, idx + 1);
        end else begin
          ef = ~idx[0];
          if (x_half !== mem[idx] || x_first !== ef) begin
            failures++;
            $display("FAIL %s pop%0d got %h/%b exp %h/%b", name, idx, x_half, x_first, mem[idx], ef);
          end
        end
        idx++;
      end
      if (done) dones++;
      if (dones > 0) post++;
      tick();
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (idx !== 1024 || dones !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s totals got pops=%0d dones=%0d busy=%b exp 1024 1 0", name, idx, dones, busy);
    end
    if (mode == 1) begin
      checks++;
      if (stall !== 20) begin
        failures++;
        $display("FAIL %s stall_cycles got %0d exp 20", name, stall);
      end
    end
  endtask

  task automatic test_reset_midrun();
    bit hit = 0, seen = 0;
    do_reset();
    lpf_ready = 1'b1; hpf_ready = 1'b1;
    for (int cyc = 0; cyc < 600 && !hit; cyc++) begin
      start = (cyc == 0);
      #1;
      if (rom_a == 10'd500) hit = 1;
      else tick();
    end
    start = 1'b0;
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL midrun_reach got rom_a=%0d exp 500", rom_a);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (x_valid !== 1'b0 || busy !== 1'b0 || rom_cen !== 1'b1 || rom_a !== 10'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL midrun_reset got v=%b busy=%b cen=%b a=%0d done=%b exp 0 0 1 0 0",
               x_valid, busy, rom_cen, rom_a, done);
    end
    for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
      start = (cyc == 0);
      #1;
      if (x_valid) seen = 1;
      else tick();
    end
    start = 1'b0;
    checks++;
    if (!seen || x_half !== mem[0] || x_first !== 1'b1) begin
      failures++;
      $display("FAIL midrun_restart got v=%b h=%h f=%b exp 1 %h 1", seen, x_half, x_first, mem[0]);
    end
  endtask

  task automatic test_no_ready();
    int issues = 0;
    do_reset();
    for (int cyc = 0; cyc < 60; cyc++) begin
      start = (cyc == 0);
      #1;
      if (!rom_cen) issues++;
      tick();
    end
    start = 1'b0;
    #1;
    checks++;
    if (issues !== 2 || rom_cen !== 1'b1 || x_valid !== 1'b1 || x_half !== mem[0] || x_first !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL no_ready got issues=%0d cen=%b v=%b h=%h f=%b busy=%b exp 2 1 1 %h 1 1",
               issues, rom_cen, x_valid, x_half, x_first, busy, mem[0]);
    end
    tick();
    do_reset();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 4'((i * 5 + (i >> 4)) ^ (i >> 8));
    test_reset();
    test_full_run();
    run_collect(1, "stall");
    run_collect(0, "random");
    run_collect(2, "start_ignored");
    test_reset_midrun();
    test_no_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mbf_rom_sched.md
# mbf_rom_sched

ROM fetch scheduler for the multi-band filter. It sequences reads of the 1024x4 sample ROM and broadcasts each returned nibble to the LPF and HPF, which consume the same stream. A delivery completes only when both filters accept it. A 2-entry skid buffer absorbs the ROM's one-cycle read latency so that filter backpressure never drops or duplicates a nibble. It replaces the free-running divided-clock address/CEN logic at top level with an explicit handshake.

## Interface
- DEPTH, 1024: number of ROM words fetched per run.
- ADDR_W, 10: ROM address width.
- DATA_W, 4: ROM word (nibble) width.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; clears all state on the next rising edge.
- start  in  1  one-cycle request to begin a run; sampled only in IDLE.
- rom_cen  out  1  ROM chip enable, active-low; combinational.
- rom_a  out  ADDR_W  ROM address; registered counter.
- rom_q  in  DATA_W  ROM data, valid in the cycle after an issue.
- lpf_ready  in  1  LPF can accept a nibble this cycle.
- hpf_ready  in  1  HPF can accept a nibble this cycle.
- x_valid  out  1  buffer head holds a nibble.
- x_half  out  DATA_W  head nibble, broadcast to both filters.
- x_first  out  1  head nibble came from an even address (high half of a sample).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE → FETCH when start=1. On this transition, rom_a is set to 0.
  - FETCH → DRAIN on the cycle that issues address DEPTH-1.
  - DRAIN → IDLE when pending=0 and the buffer becomes empty this cycle: count=0, or count=1 with pop. This transition sets done=1 for one cycle.
- pop = x_valid & lpf_ready & hpf_ready. This is a broadcast transfer: neither filter sees a nibble unless both accept it.
- issue = (state==FETCH) & (count + pending - pop < 2). rom_cen = ~issue. On issue, rom_a increments at the edge.
- pending is a 1-bit register set to issue. When pending=1, rom_q is written to the buffer tail at the end of that cycle, together with x_first = ~addr_of_issue[0].
- Buffer: 2 entries, FIFO order, with count 0..2. Push and pop in the same cycle keep count unchanged. Push into a full buffer cannot happen, because the credit rule prevents it.
- The head drives x_half and x_first. While x_valid=1 and pop=0, both outputs hold stable.
- start is ignored outside IDLE. ready inputs are ignored while x_valid=0.
- rom_a does not wrap within a run. After the final issue it holds DEPTH-1 until the next start.

## Timing
- Reset values: rom_cen=1, rom_a=0, x_valid=0, x_half=0, x_first=0, busy=0, done=0, count=0, pending=0, state=IDLE.
- Read latency from issue (cycle c) to buffer write is the end of cycle c+1. The nibble becomes visible on x_half in cycle c+2.
- Start-to-first-valid latency: start in cycle 0 gives the first issue in cycle 1 and x_valid=1 in cycle 3.
- Throughput is 1 nibble/cycle when both filters are continuously ready.
- Stall: if ready drops with count=2, issue stops immediately. The credit path is combinational from lpf_ready/hpf_ready.
- If reset asserts mid-run, all outputs take their reset values in the next cycle and in-flight data is discarded. A later start fetches from address 0.

## Test plan
- Reset, then start in cycle 0 with both readies high → x_valid=1 in cycles 3..1026 with x_half = ROM[0..1023] in order; done=1 in cycle 1027 only; busy=0 from cycle 1027.
- Hold hpf_ready=0 for 20 cycles mid-run, with lpf_ready=1 → no pop; x_half and x_first stable; rom_cen=1 once count+pending=2; after release the stream resumes with no lost or repeated address.
- Randomly toggle lpf_ready and hpf_ready independently → the received sequence equals ROM[0..1023] exactly once each; x_first reads 1,0,1,0,… starting at 1.
- Pulse start at cycle 100 of an active run → ignored; the run ends with exactly 1024 pops and a single done pulse.
- Assert reset when rom_a=500 → next cycle x_valid=0, busy=0, rom_cen=1, rom_a=0; a new start re-delivers ROM[0] first.
- Keep both readies low from start → at most 2 issues occur; count=2; rom_cen stays 1; x_half=ROM[0] held indefinitely.
